// File: rtl/des_dec_key_sched.sv
// DES decryption key schedule: loads one key, streams K16..K1
// on a valid/ready port by right-rotating the PC-1 halves.
module des_dec_key_sched #(
  parameter int PC2_REG = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        abort,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_round,
  output logic        subkey_last,
  output logic        subkey_valid,
  input  logic        subkey_ready
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FILL
  } state_t;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Table entries are DES bit numbers: bit 1 is the MSB.
  function automatic logic [55:0] pc1(
    input logic [63:0] k
  );
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(
    input logic [55:0] cd
  );
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) begin
      r[6'(47 - j)] = cd[6'(56 - PC2_T[j])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rr1(
    input logic [27:0] x
  );
    return {x[0], x[27:1]};
  endfunction

  function automatic logic [27:0] rr2(
    input logic [27:0] x
  );
    return {x[1:0], x[27:2]};
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [4:0]  n_q, n_d;
  logic [47:0] sk_q, sk_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        last_q, last_d;

  logic        vld;
  logic        hs;
  logic [4:0]  n_nx;
  logic        one;

  assign vld  = (state_q == RUN);
  assign hs   = vld & subkey_ready;
  assign n_nx = n_q + 5'd1;
  assign one  = (n_nx == 5'd2) |
                (n_nx == 5'd9) |
                (n_nx == 5'd16);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    n_d     = n_q;
    sk_d    = sk_q;
    rnd_d   = rnd_q;
    last_d  = last_q;
    if (abort) begin
      state_d = IDLE;
      n_d     = 5'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_valid) begin
            {c_d, d_d} = pc1(key);
            n_d        = 5'd1;
            state_d    = (PC2_REG != 0) ? FILL : RUN;
          end
        end
        FILL: begin
          sk_d    = pc2({c_q, d_q});
          rnd_d   = 4'(5'd16 - n_q);
          last_d  = (n_q == 5'd16);
          state_d = RUN;
        end
        RUN: begin
          if (hs) begin
            if (n_q == 5'd16) begin
              state_d = IDLE;
            end else begin
              c_d     = one ? rr1(c_q) : rr2(c_q);
              d_d     = one ? rr1(d_q) : rr2(d_q);
              n_d     = n_nx;
              state_d = (PC2_REG != 0) ? FILL : RUN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      sk_q    <= '0;
      rnd_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      n_q     <= n_d;
      sk_q    <= sk_d;
      rnd_q   <= rnd_d;
      last_q  <= last_d;
    end
  end

  assign key_ready    = (state_q == IDLE);
  assign subkey_valid = vld;

  always_comb begin
    if (PC2_REG != 0) begin
      subkey       = sk_q;
      subkey_round = rnd_q;
      subkey_last  = last_q & vld;
    end else begin
      subkey       = pc2({c_q, d_q});
      subkey_round = 4'(5'd16 - n_q);
      subkey_last  = (n_q == 5'd16) & vld;
    end
  end

endmodule
